axis_framer: RTL and testbench

// - Cuts a continuous AXI4-Stream sample stream (no framing) into fixed-length frames: tuser on first word, tlast on last.
// - Sits directly upstream of the 2-port stream mux; the mux switches inputs only on tlast, so this block supplies the boundaries.
// - Registered output stage with skid buffer: full throughput, no combinational path from output_axis_tready to input_axis_tready.

---
 rtl/axis_framer.sv | 168 ++++++++++++++++
 tb/tb_axis_framer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_framer.sv
// axis_framer: cuts a continuous AXI4-Stream sample stream into fixed-length
// frames. The first word of each frame carries tuser and the last word carries
// tlast, so the downstream stream mux can switch inputs on tlast. A registered
// output stage with a one-entry skid buffer gives full throughput. There is no
// combinational path from output_axis_tready to input_axis_tready.
module axis_framer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  input_axis_tdata,
  input  logic                   input_axis_tvalid,
  output logic                   input_axis_tready,
  output logic [DATA_WIDTH-1:0]  output_axis_tdata,
  output logic                   output_axis_tvalid,
  input  logic                   output_axis_tready,
  output logic                   output_axis_tlast,
  output logic                   output_axis_tuser,
  input  logic                   enable,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  cnt, cnt_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  in_accept;
  logic                  tag_user;
  logic                  tag_last;

  // Output register and skid register. The skid entry holds the one word
  // accepted while the output is stalled.
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_user;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  skid_last;
  logic                  skid_user;

  // A zero length request behaves as a single-word frame.
  assign len_eff = (frame_len == '0) ? LEN_ONE : frame_len;

  // Ready depends only on registered state and enable. It never depends on
  // the downstream ready.
  assign input_axis_tready = ~skid_valid & ((state == ACTIVE) | enable);
  assign in_accept         = input_axis_tvalid & input_axis_tready;

  assign busy               = (state == ACTIVE);
  assign output_axis_tdata  = out_data;
  assign output_axis_tvalid = out_valid;
  assign output_axis_tlast  = out_last;
  assign output_axis_tuser  = out_user;

  // Frame state register: position within frame and latched frame length.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_reg <= LEN_ONE;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      len_reg <= len_next;
    end
  end

  // Next-state logic and first/last tagging of the word currently offered.
  // NOTE: every output gets a default first, so no path leaves a variable
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_next   = len_reg;
    tag_user   = 1'b0;
    tag_last   = 1'b0;
    case (state)
      IDLE: begin
        tag_user = 1'b1;
        tag_last = (len_eff == LEN_ONE);
        if (in_accept) begin
          len_next = len_eff;
          if (!tag_last) begin
            cnt_next   = LEN_ONE;
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        tag_last = (cnt == len_reg - LEN_ONE);
        if (in_accept) begin
          if (tag_last) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + LEN_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output stage. The skid register drains first. Otherwise an accepted word
  // loads the output register when it is empty or draining, and the skid
  // register when the output is stalled. With no new word, a drain empties
  // the output register.
  // NOTE: the data-path registers are reset along with their valid flags so
  // that every output reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_user  <= 1'b0;
    end else begin
      if (out_valid && output_axis_tready && skid_valid) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        out_user   <= skid_user;
        skid_valid <= 1'b0;
      end else if (in_accept) begin
        if (!out_valid || output_axis_tready) begin
          out_data  <= input_axis_tdata;
          out_last  <= tag_last;
          out_user  <= tag_user;
          out_valid <= 1'b1;
        end else begin
          skid_data  <= input_axis_tdata;
          skid_last  <= tag_last;
          skid_user  <= tag_user;
          skid_valid <= 1'b1;
        end
      end else if (output_axis_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Count frames when their last word is accepted at the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (in_accept && tag_last) begin
      frame_count <= frame_count + COUNT_ONE;
    end
  end

endmodule

// File: tb/tb_axis_framer.sv
// Testbench for axis_framer. It runs directed table vectors, hand-written
// corner sequences and randomized traffic. A frame-position model and an
// expected-word queue check the traffic on every cycle.
module tb_axis_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid;
  logic        input_axis_tready;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic        output_axis_tlast;
  logic        output_axis_tuser;
  logic        enable;
  logic [15:0] frame_len;
  logic        busy;
  logic [31:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  axis_framer #(.DATA_WIDTH(8), .LEN_WIDTH(16), .COUNT_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .output_axis_tuser  (output_axis_tuser),
    .enable             (enable),
    .frame_len          (frame_len),
    .busy               (busy),
    .frame_count        (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
  } word_t;

  word_t       exp_q[$];
  int          pos = 0;          // words of the current frame already accepted
  int          cur_len = 1;      // length of the frame in progress
  logic [31:0] model_count = 0;  // frames completed at the input
  logic        stall_prev = 1'b0;
  word_t       held;

  // Handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      exp_q.delete();
      pos         = 0;
      cur_len     = 1;
      model_count = 0;
      stall_prev  = 1'b0;
    end else begin
      check("busy_model", {31'd0, busy}, {31'd0, pos != 0});
      check("frame_count_model", frame_count, model_count);
      if (pos == 0 && !enable)
        check("tready_gate", {31'd0, input_axis_tready}, 32'd0);
      if (stall_prev) begin
        check("stall_valid", {31'd0, output_axis_tvalid}, 32'd1);
        check("stall_data", {24'd0, output_axis_tdata}, {24'd0, held.data});
        check("stall_tags", {30'd0, output_axis_tuser, output_axis_tlast},
              {30'd0, held.user, held.last});
      end
      if (output_axis_tvalid && output_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", {24'd0, output_axis_tdata}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("sb_data", {24'd0, output_axis_tdata}, {24'd0, w.data});
          check("sb_tags", {30'd0, output_axis_tuser, output_axis_tlast},
                {30'd0, w.user, w.last});
        end
      end
      stall_prev = output_axis_tvalid && !output_axis_tready;
      held.data  = output_axis_tdata;
      held.user  = output_axis_tuser;
      held.last  = output_axis_tlast;
      if (input_axis_tvalid && input_axis_tready) begin
        if (pos == 0) cur_len = (frame_len == 16'd0) ? 1 : int'(frame_len);
        w.data = input_axis_tdata;
        w.user = (pos == 0);
        w.last = (pos == cur_len - 1);
        exp_q.push_back(w);
        if (w.last) begin
          model_count = model_count + 1;
          pos = 0;
        end else begin
          pos = pos + 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    input_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offer one word and expect it to be taken on the next rising edge.
  task automatic send_word(input logic [7:0] d, input string nm);
    input_axis_tdata  = d;
    input_axis_tvalid = 1'b1;
    #1;
    check(nm, {31'd0, input_axis_tready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    input_axis_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    input_axis_tvalid  = 1'b0;
    output_axis_tready = 1'b1;
    while (exp_q.size() != 0 && guard < 20) begin @(posedge clk); #1; guard++; end
    check(nm, exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] len;
    logic        exp_user;
    logic        exp_last;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_sent;
    int          cycles;
    logic [7:0]  next_data;

    // word 0x10..0x17 with len 4, then single-word frames with len 0/1/0
    vecs[0]  = '{8'h10, 16'd4, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{8'h11, 16'd4, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h12, 16'd4, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h13, 16'd4, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h14, 16'd4, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'h15, 16'd4, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h16, 16'd4, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h17, 16'd4, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h20, 16'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{8'h21, 16'd1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'h22, 16'd0, 1'b1, 1'b1, 1'b0};

    rst_n              = 1'b0;
    input_axis_tdata   = 8'h00;
    input_axis_tvalid  = 1'b0;
    output_axis_tready = 1'b0;
    enable             = 1'b0;
    frame_len          = 16'd4;
    #2;
    check("rst_tvalid", {31'd0, output_axis_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, output_axis_tdata}, 32'd0);
    check("rst_tags", {30'd0, output_axis_tuser, output_axis_tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", frame_count, 32'd0);
    check("rst_tready", {31'd0, input_axis_tready}, 32'd0);
    do_reset();

    // ---- table vectors, back-to-back with downstream ready ----
    enable = 1'b1;
    output_axis_tready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) begin
        do_reset();
      end
      frame_len = vecs[i].len;
      send_word(vecs[i].data, "tbl_ready");
      check("tbl_valid", {31'd0, output_axis_tvalid}, 32'd1);
      check("tbl_data", {24'd0, output_axis_tdata}, {24'd0, vecs[i].data});
      check("tbl_user", {31'd0, output_axis_tuser}, {31'd0, vecs[i].exp_user});
      check("tbl_last", {31'd0, output_axis_tlast}, {31'd0, vecs[i].exp_last});
      check("tbl_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      if (i == 7) check("tbl_count_a", frame_count, 32'd2);
    end
    check("tbl_count_b", frame_count, 32'd3);
    drain("tbl_drain");

    // ---- enable dropped mid-frame: frame still completes ----
    frame_len = 16'd5;
    send_word(8'h50, "en_w1");
    send_word(8'h51, "en_w2");
    enable = 1'b0;
    send_word(8'h52, "en_w3");
    send_word(8'h53, "en_w4");
    send_word(8'h54, "en_w5");
    check("en_last", {31'd0, output_axis_tlast}, 32'd1);
    check("en_busy_done", {31'd0, busy}, 32'd0);
    input_axis_tdata = 8'h55;
    repeat (3) begin
      #1;
      check("en_blocked", {31'd0, input_axis_tready}, 32'd0);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    send_word(8'h55, "en_resume");
    check("en_resume_user", {31'd0, output_axis_tuser}, 32'd1);
    check("en_busy_again", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) send_word(8'h56 + 8'(k), "en_tail");
    check("en_tail_last", {31'd0, output_axis_tlast}, 32'd1);
    drain("en_drain");

    // ---- frame_len changed mid-frame: takes effect at next frame ----
    frame_len = 16'd4;
    send_word(8'h70, "lc_w1");
    frame_len = 16'd2;
    send_word(8'h71, "lc_w2");
    send_word(8'h72, "lc_w3");
    check("lc_w3_last", {31'd0, output_axis_tlast}, 32'd0);
    send_word(8'h73, "lc_w4");
    check("lc_w4_last", {31'd0, output_axis_tlast}, 32'd1);
    send_word(8'h74, "lc_w5");
    check("lc_w5_user", {31'd0, output_axis_tuser}, 32'd1);
    send_word(8'h75, "lc_w6");
    check("lc_w6_last", {31'd0, output_axis_tlast}, 32'd1);
    check("lc_busy", {31'd0, busy}, 32'd0);
    check("lc_count", frame_count, 32'd7);
    drain("lc_drain");

    // ---- asynchronous reset in the middle of a frame ----
    frame_len = 16'd4;
    send_word(8'h60, "rs_w1");
    send_word(8'h61, "rs_w2");
    input_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rs_tvalid", {31'd0, output_axis_tvalid}, 32'd0);
    check("rs_tdata", {24'd0, output_axis_tdata}, 32'd0);
    check("rs_tags", {30'd0, output_axis_tuser, output_axis_tlast}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_count", frame_count, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(8'h62, "rs_after");
    check("rs_after_user", {31'd0, output_axis_tuser}, 32'd1);
    check("rs_after_data", {24'd0, output_axis_tdata}, 32'h62);
    check("rs_after_count", frame_count, 32'd0);
    do_reset();

    // ---- random downstream stalls, frame_len = 3, 300 words ----
    frame_len = 16'd3;
    enable    = 1'b1;
    n_sent    = 0;
    cycles    = 0;
    next_data = 8'h00;
    while (n_sent < 300 && cycles < 5000) begin
      input_axis_tvalid  = ($urandom_range(0, 9) != 0);
      input_axis_tdata   = next_data;
      output_axis_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (input_axis_tvalid && input_axis_tready) begin
        next_data = next_data + 8'd1;
        n_sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("rnd_sent", n_sent, 32'd300);
    drain("rnd_drain");
    check("rnd_count", frame_count, 32'd100);

    // ---- fully random: enable, frame_len, valid and ready all vary ----
    for (int c = 0; c < 400; c++) begin
      input_axis_tvalid  = 1'($urandom_range(0, 1));
      input_axis_tdata   = 8'($urandom);
      enable             = ($urandom_range(0, 3) != 0);
      frame_len          = 16'($urandom_range(0, 6));
      output_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain("mix_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
